keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Scan controller for the 4x4 matrix keypad. Drives one column low at a time and samples the
//  four row lines on a slow scan tick. Debounces a candidate key over consecutive ticks.
//  Reports each debounced press exactly once as a 4-bit key code with a valid/ack handshake.
//  Sits between the keypad pins and the code-entry logic; it replaces free-running per-line
//  debounce shift registers with one sequenced controller.
// PARAMETERS
//  TICK_DIV  50000  Clock cycles per scan/sample tick (>=2)
//  DEB_LEN   4      Consecutive matching tick samples needed to accept a press or a release (1..15)
// PORTS
//  Clock     in   1  System clock, all logic on posedge
//  Resetn    in   1  Asynchronous, active-low reset
//  Row       in   4  Keypad rows, active-low (pulled up); asynchronous to Clock
//  Col       out  4  Column drive, active-low one-hot (exactly one bit 0 at all times)
//  KeyCode   out  4  Debounced key = {row_idx[1:0], col_idx[1:0]}
//  KeyValid  out  1  KeyCode valid; held until acknowledged
//  KeyAck    in   1  Consumer accepts KeyCode; sampled only while KeyValid=1
//  Busy      out  1  1 in any state except SCAN
// BEHAVIOUR
//  Reset (async assert, sync use after deassert):
//   Col=4'b1110, KeyValid=0, KeyCode=0, Busy=0, state=SCAN. Tick and debounce counters=0.
//   Asserting reset mid-operation abandons any pending key; a press already latched is lost.
//  Row synchroniser: 2-flop chain; all decisions use the synchronised value rs.
//  Tick: counter 0..TICK_DIV-1, wraps; tick=1 for one cycle when counter==TICK_DIV-1.
//  Row pattern valid only if exactly one bit of rs is 0 (one-hot-low).
//   All-ones means no key. Multi-low (ghost/multi-key) is treated as no key.
//  FSM, transitions only on tick cycles:
//   SCAN: valid pattern on current column -> store row_idx, cnt=1, go DEBOUNCE
//         (if DEB_LEN=1, go straight to HOLD).
//         Otherwise rotate column 0->1->2->3->0 (Col 1110->1101->1011->0111->1110).
//   DEBOUNCE: column frozen. Same row pattern -> cnt++.
//         When cnt reaches DEB_LEN: KeyCode={row_idx,col_idx}, KeyValid=1, go HOLD.
//         Different pattern -> cnt=0, go SCAN on same column (no rotate this tick).
//   HOLD: column frozen; no tick dependency.
//         KeyAck=1 while KeyValid=1 -> KeyValid=0 on the next edge, cnt=0, go RELEASE.
//         KeyCode keeps its value until the next accepted press.
//   RELEASE: rs==4'b1111 -> cnt++, else cnt=0.
//         cnt reaches DEB_LEN -> go SCAN and rotate to next column.
//  Latency: KeyValid rises 1 cycle after the DEB_LEN-th consecutive matching tick sample.
//   Plus 2 cycles of synchroniser delay from pin.
//  KeyAck while KeyValid=0 is ignored. A held key never re-reports; auto-repeat is not supported.
//  Keys on other columns are not seen while DEBOUNCE/HOLD/RELEASE.
//  cnt width = clog2(DEB_LEN+1); never wraps (saturates at DEB_LEN).
// TESTING (TICK_DIV=4, DEB_LEN=4)
//  Reset: Resetn=0 mid-DEBOUNCE -> Col=1110, KeyValid=0, KeyCode=0, Busy=0 immediately.
//  Idle scan: Row=1111 -> Col steps 1110,1101,1011,0111,1110, one step every 4 cycles.
//  Clean press: Row=1011 while Col=1101 for 6 ticks -> KeyValid=1, KeyCode=4'b1001.
//   Ack -> KeyValid=0 next cycle.
//  Bounce: row toggles low/high every tick for 10 ticks, then steady low 4 ticks -> exactly one KeyValid.
//  Hold without ack 100 ticks -> KeyValid stays 1, KeyCode stable.
//   Release only after ack + 4 high ticks; Busy drops then.
//  Ghost: Row=1001 -> no KeyValid, scan keeps rotating. KeyAck pulse while idle -> no effect.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl_if
// Description : Key report handshake between the keypad scan controller
//               (master) and the code-entry logic (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scan_ctrl_if;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyAck;
  logic       Busy;

  modport master (
    output KeyCode,
    output KeyValid,
    output Busy,
    input  KeyAck
  );

  modport slave (
    input  KeyCode,
    input  KeyValid,
    input  Busy,
    output KeyAck
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : 4x4 matrix keypad scanner. Walks an active-low column strobe,
//               debounces a single-key row pattern over consecutive scan
//               ticks and reports each press once over a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int DEB_LEN  = 4
) (
  input  wire logic          Clock,
  input  wire logic          Resetn,
  input  wire logic [3:0]    Row,
  output logic [3:0]         Col,
  keypad_scan_ctrl_if.master key
);

  localparam int                  c_TICK_W    = $clog2(TICK_DIV);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam int                  c_CNT_W     = $clog2(DEB_LEN + 1);
  localparam logic [c_CNT_W-1:0]  c_DEB_MAX   = c_CNT_W'(DEB_LEN);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [3:0]          r_row_meta;
  logic [3:0]          r_rs;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;

  state_t              r_state,     w_state_nx;
  logic [1:0]          r_col_idx,   w_col_nx;
  logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nx;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic [1:0]          r_row_idx,   w_row_idx_nx;
  logic [3:0]          r_key_code,  w_code_nx;
  logic                r_key_valid, w_valid_nx;

  logic                w_row_ok;
  logic [1:0]          w_row_idx;

  // Two-flop synchroniser for the asynchronous row pins (idle level is all-ones)
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_row_meta <= 4'hF;
      r_rs       <= 4'hF;
    end else begin
      r_row_meta <= Row;
      r_rs       <= r_row_meta;
    end
  end

  // Free-running scan tick divider
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == c_TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  // Only a single low row is a usable key; ghosting/multi-key reads as no key
  always_comb begin
    w_row_ok  = 1'b1;
    w_row_idx = 2'd0;
    case (r_rs)
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_row_ok  = 1'b0;
    endcase
  end

  // Controller state and report registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= ST_SCAN;
      r_col_idx   <= 2'd0;
      r_cnt       <= '0;
      r_row_idx   <= 2'd0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_col_idx   <= w_col_nx;
      r_cnt       <= w_cnt_nx;
      r_row_idx   <= w_row_idx_nx;
      r_key_code  <= w_code_nx;
      r_key_valid <= w_valid_nx;
    end
  end

  // Next-state logic: everything except the ack in HOLD advances on ticks only
  always_comb begin
    w_state_nx   = r_state;
    w_col_nx     = r_col_idx;
    w_cnt_nx     = r_cnt;
    w_row_idx_nx = r_row_idx;
    w_code_nx    = r_key_code;
    w_valid_nx   = r_key_valid;
    // Counter saturates so it can never wrap back into a false match
    w_cnt_inc    = (r_cnt == c_DEB_MAX) ? r_cnt : r_cnt + c_CNT_ONE;

    case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (w_row_ok) begin
            w_row_idx_nx = w_row_idx;
            w_cnt_nx     = c_CNT_ONE;
            if (DEB_LEN == 1) begin
              w_code_nx  = {w_row_idx, r_col_idx};
              w_valid_nx = 1'b1;
              w_state_nx = ST_HOLD;
            end else begin
              w_state_nx = ST_DEBOUNCE;
            end
          end else begin
            w_col_nx = r_col_idx + 2'd1;
          end
        end
      end

      ST_DEBOUNCE: begin
        if (w_tick) begin
          if (w_row_ok && (w_row_idx == r_row_idx)) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == c_DEB_MAX) begin
              w_code_nx  = {r_row_idx, r_col_idx};
              w_valid_nx = 1'b1;
              w_state_nx = ST_HOLD;
            end
          end else begin
            // Retry the same column on the next tick rather than moving on
            w_cnt_nx   = '0;
            w_state_nx = ST_SCAN;
          end
        end
      end

      ST_HOLD: begin
        if (r_key_valid && key.KeyAck) begin
          w_valid_nx = 1'b0;
          w_cnt_nx   = '0;
          w_state_nx = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (w_tick) begin
          if (r_rs == 4'hF) begin
            w_cnt_nx = w_cnt_inc;
            if (w_cnt_inc == c_DEB_MAX) begin
              w_cnt_nx   = '0;
              w_col_nx   = r_col_idx + 2'd1;
              w_state_nx = ST_SCAN;
            end
          end else begin
            w_cnt_nx = '0;
          end
        end
      end

      default: begin
        w_state_nx = ST_SCAN;
      end
    endcase
  end

  assign Col          = ~(4'b0001 << r_col_idx);
  assign key.KeyCode  = r_key_code;
  assign key.KeyValid = r_key_valid;
  assign key.Busy     = (r_state != ST_SCAN);

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_ctrl
// Description : Directed self-checking bench for keypad_scan_ctrl with
//               TICK_DIV=4 and DEB_LEN=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] Row;
  logic [3:0] Col;

  keypad_scan_ctrl_if key_bus ();

  keypad_scan_ctrl #(
    .TICK_DIV (4),
    .DEB_LEN  (4)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Row    (Row),
    .Col    (Col),
    .key    (key_bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  int rises  = 0;
  int base   = 0;
  logic r_prev_valid = 1'b0;

  // Count KeyValid rising edges to prove one report per press
  always @(posedge Clock) begin
    r_prev_valid <= key_bus.KeyValid;
    if (key_bus.KeyValid && !r_prev_valid) rises <= rises + 1;
  end

  // Advance n clock cycles, tracking position within the 4-cycle tick period
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      phase = (phase + 1) % 4;
    end
  endtask

  // Advance to the negedge right after the next tick edge
  task automatic to_next_tick();
    cycles(4 - phase);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) to_next_tick();
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    Row = 4'hF;
    key_bus.KeyAck = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", Col); end
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", key_bus.KeyValid); end
    checks++; if (key_bus.KeyCode !== 4'b0000) begin errors++; $display("FAIL reset_code: got %b expected 0000", key_bus.KeyCode); end
    checks++; if (key_bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", key_bus.Busy); end
    Resetn = 1'b1;
    phase = 0;
    cycles(3);
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL post_reset_col: got %b expected 1110", Col); end
    to_next_tick();
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col [4];
    exp_col[0] = 4'b1101; exp_col[1] = 4'b1011; exp_col[2] = 4'b0111; exp_col[3] = 4'b1110;
    // The first tick after reset already happened in test_reset
    checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL idle_col_start: got %b expected 1101", Col); end
    for (int i = 1; i < 4; i++) begin
      cycles(2);
      checks++; if (Col !== exp_col[i-1]) begin errors++; $display("FAIL idle_col_mid%0d: got %b expected %b", i, Col, exp_col[i-1]); end
      to_next_tick();
      checks++; if (Col !== exp_col[i]) begin errors++; $display("FAIL idle_col_step%0d: got %b expected %b", i, Col, exp_col[i]); end
      checks++; if (key_bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_busy%0d: got %b expected 0", i, key_bus.Busy); end
    end
    tick(1);
  endtask

  task automatic test_clean_press();
    base = rises;
    checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL press_col_pre: got %b expected 1101", Col); end
    Row = 4'b1011;
    tick(3);
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL press_early_valid: got %b expected 0", key_bus.KeyValid); end
    checks++; if (key_bus.Busy !== 1'b1) begin errors++; $display("FAIL press_debounce_busy: got %b expected 1", key_bus.Busy); end
    cycles(3);
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL press_pre_tick_valid: got %b expected 0", key_bus.KeyValid); end
    cycles(1);
    checks++; if (key_bus.KeyValid !== 1'b1) begin errors++; $display("FAIL press_valid: got %b expected 1", key_bus.KeyValid); end
    checks++; if (key_bus.KeyCode !== 4'b1001) begin errors++; $display("FAIL press_code: got %b expected 1001", key_bus.KeyCode); end
    checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL press_col_frozen: got %b expected 1101", Col); end
    tick(2);
    checks++; if (key_bus.KeyValid !== 1'b1) begin errors++; $display("FAIL press_valid_held: got %b expected 1", key_bus.KeyValid); end
    key_bus.KeyAck = 1'b1;
    cycles(1);
    key_bus.KeyAck = 1'b0;
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL ack_valid: got %b expected 0", key_bus.KeyValid); end
    checks++; if (key_bus.Busy !== 1'b1) begin errors++; $display("FAIL ack_busy: got %b expected 1", key_bus.Busy); end
    checks++; if (key_bus.KeyCode !== 4'b1001) begin errors++; $display("FAIL ack_code_kept: got %b expected 1001", key_bus.KeyCode); end
    to_next_tick();
    Row = 4'hF;
    tick(3);
    checks++; if (key_bus.Busy !== 1'b1) begin errors++; $display("FAIL release_busy: got %b expected 1", key_bus.Busy); end
    checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL release_col: got %b expected 1101", Col); end
    tick(1);
    checks++; if (key_bus.Busy !== 1'b0) begin errors++; $display("FAIL release_done_busy: got %b expected 0", key_bus.Busy); end
    checks++; if (Col !== 4'b1011) begin errors++; $display("FAIL release_rotate: got %b expected 1011", Col); end
    checks++; if (rises - base !== 1) begin errors++; $display("FAIL press_reports: got %0d expected 1", rises - base); end
  endtask

  task automatic test_bounce_and_hold();
    base = rises;
    for (int i = 0; i < 10; i++) begin
      Row = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      tick(1);
    end
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL bounce_valid: got %b expected 0", key_bus.KeyValid); end
    checks++; if (Col !== 4'b1011) begin errors++; $display("FAIL bounce_col: got %b expected 1011", Col); end
    Row = 4'b1110;
    tick(3);
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL bounce_early_valid: got %b expected 0", key_bus.KeyValid); end
    tick(1);
    checks++; if (key_bus.KeyValid !== 1'b1) begin errors++; $display("FAIL bounce_valid_final: got %b expected 1", key_bus.KeyValid); end
    checks++; if (key_bus.KeyCode !== 4'b0010) begin errors++; $display("FAIL bounce_code: got %b expected 0010", key_bus.KeyCode); end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checks++;
      if (key_bus.KeyValid !== 1'b1 || key_bus.KeyCode !== 4'b0010) begin
        errors++; $display("FAIL hold_tick%0d: got valid=%b code=%b expected valid=1 code=0010", i, key_bus.KeyValid, key_bus.KeyCode);
      end
    end
    Row = 4'hF;
    tick(6);
    checks++; if (key_bus.KeyValid !== 1'b1) begin errors++; $display("FAIL hold_release_no_ack: got %b expected 1", key_bus.KeyValid); end
    checks++; if (key_bus.Busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b expected 1", key_bus.Busy); end
    checks++; if (rises - base !== 1) begin errors++; $display("FAIL bounce_reports: got %0d expected 1", rises - base); end
    key_bus.KeyAck = 1'b1;
    cycles(1);
    key_bus.KeyAck = 1'b0;
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL hold_ack_valid: got %b expected 0", key_bus.KeyValid); end
    to_next_tick();
    tick(2);
    checks++; if (key_bus.Busy !== 1'b1) begin errors++; $display("FAIL hold_release_busy: got %b expected 1", key_bus.Busy); end
    tick(1);
    checks++; if (key_bus.Busy !== 1'b0) begin errors++; $display("FAIL hold_release_done: got %b expected 0", key_bus.Busy); end
    checks++; if (Col !== 4'b0111) begin errors++; $display("FAIL hold_release_col: got %b expected 0111", Col); end
  endtask

  task automatic test_ghost_and_idle_ack();
    base = rises;
    Row = 4'b1001;
    tick(1);
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL ghost_col1: got %b expected 1110", Col); end
    tick(1);
    checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL ghost_col2: got %b expected 1101", Col); end
    checks++; if (key_bus.Busy !== 1'b0) begin errors++; $display("FAIL ghost_busy: got %b expected 0", key_bus.Busy); end
    key_bus.KeyAck = 1'b1;
    cycles(1);
    key_bus.KeyAck = 1'b0;
    checks++; if (key_bus.KeyValid !== 1'b0 || key_bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_ack: got valid=%b busy=%b expected 0 0", key_bus.KeyValid, key_bus.Busy); end
    checks++; if (key_bus.KeyCode !== 4'b0010) begin errors++; $display("FAIL idle_ack_code: got %b expected 0010", key_bus.KeyCode); end
    to_next_tick();
    checks++; if (Col !== 4'b1011) begin errors++; $display("FAIL ghost_col3: got %b expected 1011", Col); end
    checks++; if (rises - base !== 0) begin errors++; $display("FAIL ghost_reports: got %0d expected 0", rises - base); end
    Row = 4'hF;
  endtask

  task automatic test_reset_mid_debounce();
    Row = 4'b0111;
    tick(2);
    checks++; if (key_bus.Busy !== 1'b1) begin errors++; $display("FAIL mid_deb_busy: got %b expected 1", key_bus.Busy); end
    #2 Resetn = 1'b0;
    #1;
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL async_reset_col: got %b expected 1110", Col); end
    checks++; if (key_bus.KeyValid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", key_bus.KeyValid); end
    checks++; if (key_bus.KeyCode !== 4'b0000) begin errors++; $display("FAIL async_reset_code: got %b expected 0000", key_bus.KeyCode); end
    checks++; if (key_bus.Busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", key_bus.Busy); end
    Row = 4'hF;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    phase = 0;
    tick(1);
    checks++; if (Col !== 4'b1101 || key_bus.Busy !== 1'b0) begin errors++; $display("FAIL after_reset_scan: got col=%b busy=%b expected 1101 0", Col, key_bus.Busy); end
  endtask

  // Bound the run in case the design stalls the stimulus
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle_scan();
    test_clean_press();
    test_bounce_and_hold();
    test_ghost_and_idle_ack();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
